// File: rtl/spart_rx_if.sv
// -----------------------------------------------------------------------------
// spart_rx_if
//   Bundles the SPART receive engine's signals.
//   The baud generator supplies os_tick, the pad supplies rxd, and the bus
//   interface supplies clr_rda and consumes the status/data outputs.
//
//   slave  modport : the receive engine (spart_rx) side
//   master modport : the driving side (baud gen / pad / bus interface)
//
//   os_tick   : one-clk oversample pulse, OS_RATE per bit time
//   rxd       : asynchronous serial input, idles high
//   clr_rda   : one-clk pulse on bus read of the receive buffer
//   rx_data   : last received byte
//   rda       : receive data available
//   frame_err : stop bit of the byte in rx_data sampled 0
//   overrun   : sticky, byte loaded while rda was already set
//   busy      : frame in progress
// -----------------------------------------------------------------------------
interface spart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 os_tick;
    logic                 rxd;
    logic                 clr_rda;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport slave (
        input  os_tick,
        input  rxd,
        input  clr_rda,
        output rx_data,
        output rda,
        output frame_err,
        output overrun,
        output busy
    );

    modport master (
        output os_tick,
        output rxd,
        output clr_rda,
        input  rx_data,
        input  rda,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/spart_rx.sv
// -----------------------------------------------------------------------------
// spart_rx
//   SPART serial receive engine. Synchronizes the asynchronous rxd line,
//   detects the start-bit falling edge, and re-centres sampling on it with a
//   local oversample phase counter so every bit is sampled at its centre
//   regardless of the baud generator's phase. Receives an N-data-bit, no
//   parity, one stop bit frame LSB first and presents the result with
//   data-available, framing-error and overrun status.
//
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : spart_rx_if.slave
//               in : os_tick, rxd, clr_rda
//               out: rx_data, rda, frame_err, overrun, busy
//
//   Parameters:
//     OS_RATE   : oversample ticks per bit (power of two, >= 8)
//     DATA_BITS : data bits per frame (5..8)
// -----------------------------------------------------------------------------
module spart_rx #(
    parameter int OS_RATE   = 16,
    parameter int DATA_BITS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    spart_rx_if.slave     bus
);

    localparam int PH_W = $clog2(OS_RATE);
    localparam int BC_W = $clog2(DATA_BITS);

    // Phase value just before the tick that reaches the half-bit point
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(OS_RATE / 2 - 1);
    // Phase value just before the tick that completes a full bit time
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS_RATE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e                 state_q,   state_d;
    logic [PH_W-1:0]        phase_q,   phase_d;
    logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,   shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rda_q,     rda_d;
    logic                   fe_q,      fe_d;
    logic                   ovr_q,     ovr_d;

    // Two synchronizer stages plus one history stage for edge detection
    logic                   sync1_q, sync2_q, sync3_q;
    logic                   rxd_sync;
    logic                   fall;

    assign rxd_sync = sync2_q;
    assign fall     = sync3_q & ~sync2_q;

    // Synchronizer: resets to the idle (high) line level so that reset
    // release never fabricates a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= bus.rxd;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rda_q     <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        fe_d      = fe_q;
        ovr_d     = ovr_q;

        // A bus read clears status; a load later in this block overrides it.
        if (bus.clr_rda) begin
            rda_d = 1'b0;
            ovr_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                // os_tick is ignored here; the edge detector runs every clk.
                if (fall) begin
                    state_d = S_START;
                    phase_d = '0;
                end
            end

            S_START: begin
                if (bus.os_tick) begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PH_HALF) begin
                        // Half a bit after the edge: still low means a real
                        // start bit, otherwise it was a glitch.
                        if (rxd_sync) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end
                        phase_d = '0;
                    end
                end
            end

            S_DATA: begin
                if (bus.os_tick) begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PH_LAST) begin
                        // Right shift so the first (LSB) bit ends up at bit 0
                        shift_d   = {rxd_sync, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        phase_d   = '0;
                        if (bit_cnt_q == BC_LAST) begin
                            state_d = S_STOP;
                        end
                    end
                end
            end

            S_STOP: begin
                if (bus.os_tick) begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PH_LAST) begin
                        rx_data_d = shift_q;
                        fe_d      = ~rxd_sync;
                        rda_d     = 1'b1;
                        // Overrun only when the previous byte is unread and
                        // not being read in this very clk.
                        ovr_d     = ovr_q | (rda_q & ~bus.clr_rda);
                        state_d   = S_IDLE;
                        phase_d   = '0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rda       = rda_q;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ovr_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// -----------------------------------------------------------------------------
// tb_spart_rx
//   Bench for spart_rx. A frame-level reference model counts oversample ticks
//   from the detected start edge and derives the sampling points, the loaded
//   byte and the status flags from that count; every clock the DUT outputs are
//   compared with it. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_spart_rx;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int DIV      = 4;
    localparam int BIT_CLKS = OS * DIV;
    localparam int H        = OS / 2;
    localparam int LOAD_TK  = H + (DB + 1) * OS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spart_rx_if #(.DATA_BITS(DB)) bus ();

    spart_rx #(.OS_RATE(OS), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic rxd      = 1'b1;
    logic clr_req  = 1'b0;
    logic clr_auto = 1'b0;
    logic tick     = 1'b0;
    bit   arm_clr  = 1'b0;
    int   clr_auto_cnt = 0;
    int   tdiv     = 0;

    assign bus.rxd     = rxd;
    assign bus.os_tick = tick;
    assign bus.clr_rda = clr_req | clr_auto;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    bit          m_active;
    int          m_ticks;
    logic [DB-1:0] m_data, m_rx;
    bit          m_rda, m_fe, m_ov;
    bit          h1, h2, h3;

    always @(posedge clk or negedge rst_n) begin
        int  k;
        int  b;
        bit  load;
        if (!rst_n) begin
            m_active <= 1'b0;
            m_ticks  <= 0;
            m_data   <= '0;
            m_rx     <= '0;
            m_rda    <= 1'b0;
            m_fe     <= 1'b0;
            m_ov     <= 1'b0;
            h1       <= 1'b1;
            h2       <= 1'b1;
            h3       <= 1'b1;
        end else begin
            load = 1'b0;
            if (!m_active) begin
                if (h3 && !h2) begin
                    m_active <= 1'b1;
                    m_ticks  <= 0;
                end
            end else if (tick) begin
                k = m_ticks + 1;
                m_ticks <= k;
                if (k == H) begin
                    if (h2) m_active <= 1'b0;
                end else if (k > H && ((k - H) % OS) == 0) begin
                    b = (k - H) / OS;
                    if (b <= DB) begin
                        m_data[b-1] <= h2;
                    end else begin
                        load = 1'b1;
                        m_rx     <= m_data;
                        m_fe     <= !h2;
                        m_rda    <= 1'b1;
                        if (m_rda && !bus.clr_rda) m_ov <= 1'b1;
                        m_active <= 1'b0;
                    end
                end
            end
            if (!load && bus.clr_rda) begin
                m_rda <= 1'b0;
                m_ov  <= 1'b0;
            end
            h1 <= rxd;
            h2 <= h1;
            h3 <= h2;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit rda_prev = 1'b0;
    int rise_cyc = 0;

    always @(posedge clk) begin
        #1;
        chk("rx_data",   32'(bus.rx_data),   32'(m_rx));
        chk("rda",       32'(bus.rda),       32'(m_rda));
        chk("frame_err", 32'(bus.frame_err), 32'(m_fe));
        chk("overrun",   32'(bus.overrun),   32'(m_ov));
        chk("busy",      32'(bus.busy),      32'(m_active));
        if (bus.rda && !rda_prev) rise_cyc = cyc;
        rda_prev = bus.rda;
    end

    // ---------------- oversample tick source ----------------
    always @(negedge clk) begin
        tdiv = (tdiv + 1) % DIV;
        tick = (tdiv == 0);
        // Lands the clear pulse on the clk that loads the stop bit
        clr_auto = arm_clr && tick && m_active && (m_ticks == LOAD_TK - 1);
        if (clr_auto) clr_auto_cnt++;
    end

    // ---------------- stimulus ----------------
    int start_cyc = 0;

    task automatic send(input logic [DB-1:0] d, input bit stopb);
        @(negedge clk);
        rxd = 1'b0;
        start_cyc = cyc;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = stopb;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [DB-1:0] d, input bit r,
                           input bit fe, input bit ov);
        chk({tag, ".rx_data"},   32'(bus.rx_data),   32'(d));
        chk({tag, ".rda"},       32'(bus.rda),       32'(r));
        chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(fe));
        chk({tag, ".overrun"},   32'(bus.overrun),   32'(ov));
    endtask

    initial begin
        int lat;
        int cnt0;
        logic [DB-1:0] d;
        bit sb;

        // reset state
        idle(3);
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // clean 0xA5 and its latency from the start edge
        send(8'hA5, 1'b1);
        lat = rise_cyc - start_cyc - 1;
        chk("a5.latency_ok", 32'((lat >= 604) && (lat <= 616)), 32'd1);
        chk_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        pulse_clr();
        idle(2);
        chk("a5.clr_rda", 32'(bus.rda), 32'd0);

        // short low glitch: START entered, then aborted at the half-bit check
        @(negedge clk);
        rxd = 1'b0;
        idle(3 * DIV);
        rxd = 1'b1;
        chk("glitch.busy_on", 32'(bus.busy), 32'd1);
        idle(20 * DIV);
        chk("glitch.busy_off", 32'(bus.busy), 32'd0);
        chk("glitch.rda", 32'(bus.rda), 32'd0);

        // break-like frame: stop bit 0, line then held low
        send(8'h3C, 1'b0);
        chk_out("brk", 8'h3C, 1'b1, 1'b1, 1'b0);
        idle(5 * BIT_CLKS);
        chk("brk.no_rearm_busy", 32'(bus.busy), 32'd0);
        rxd = 1'b1;
        idle(BIT_CLKS);
        pulse_clr();

        // two frames without reading: overrun
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        chk_out("ovr", 8'h22, 1'b1, 1'b0, 1'b1);
        pulse_clr();
        idle(2);
        chk_out("ovr.clr", 8'h22, 1'b0, 1'b0, 1'b0);

        // clear in the same clk as the load: load wins, overrun untouched
        send(8'h33, 1'b1);
        chk_out("pre7e", 8'h33, 1'b1, 1'b0, 1'b0);
        cnt0 = clr_auto_cnt;
        arm_clr = 1'b1;
        send(8'h7E, 1'b1);
        arm_clr = 1'b0;
        chk("same.clr_fired", 32'(clr_auto_cnt - cnt0), 32'd1);
        chk_out("same", 8'h7E, 1'b1, 1'b0, 1'b0);

        // reset during the 4th data bit of a frame
        @(negedge clk);
        rxd = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b1 ^ i[0];
            idle(BIT_CLKS);
        end
        rxd = 1'b1;
        idle(BIT_CLKS / 2);
        rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_mid.busy", 32'(bus.busy), 32'd0);
        idle(4);
        rst_n = 1'b1;
        idle(BIT_CLKS);
        send(8'h5A, 1'b1);
        chk_out("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0);
        pulse_clr();

        // randomized frames, gaps, stop bits and reads
        for (int n = 0; n < 12; n++) begin
            d  = DB'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            idle($urandom_range(1, 100));
            send(d, sb);
            chk("rand.rx_data", 32'(bus.rx_data), 32'(d));
            chk("rand.frame_err", 32'(bus.frame_err), 32'(!sb));
            if (!sb) begin
                idle($urandom_range(1, 3 * BIT_CLKS));
                rxd = 1'b1;
                idle(BIT_CLKS);
            end
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end

        idle(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Serial receive engine for the SPART. It sits downstream of the baud rate generator and consumes its 16x oversample enable, i.e. the divisor-counter expiry pulse.
- Detects the start bit on the asynchronous rxd line and re-centres sampling on it with its own phase counter. Shifts in an 8N1 frame LSB-first.
- Presents the byte to the bus interface with a receive-data-available flag and framing and overrun status.
- Uses a local phase counter, not the generator's free-running receive enable, so each frame is sampled mid-bit regardless of generator phase.

Parameters:
OS_RATE, 16, oversample ticks per bit; power of two, minimum 8.
DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset; asynchronous, active-low.
os_tick  input  1  one-clk pulse, OS_RATE per bit time, from the baud rate generator.
rxd  input  1  asynchronous serial input; idles high.
clr_rda  input  1  one-clk pulse from the bus read of the receive buffer; clears rda and overrun.
rx_data  output  DATA_BITS  last received byte; held until the next frame completes.
rda  output  1  receive data available.
frame_err  output  1  stop bit of the byte in rx_data sampled 0.
overrun  output  1  sticky; a byte was loaded while rda was already set.
busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset values: rx_data=0, rda=0, frame_err=0, overrun=0, busy=0, state=IDLE. Synchronizer flops reset to 1; phase and bit counters reset to 0.
- Reset asserted mid-frame aborts the frame. No partial byte is loaded.
- rxd passes through a 2-flop synchronizer, then a third flop for edge detection. Start is a falling edge of the synchronized rxd.
- The phase counter is log2(OS_RATE) bits wide. It advances only on os_tick and is cleared on each state entry.
- IDLE: on falling edge -> START. Edge detection runs every clk, independent of os_tick.
- START: on the os_tick that makes phase == OS_RATE/2 (8th tick), sample rxd_sync.
  - If 1: false start -> IDLE, with no flags changed.
  - If 0: -> DATA, phase=0, bit_cnt=0.
- DATA: on every OS_RATE-th os_tick, i.e. each bit centre:
  - Shift rxd_sync into the MSB of the shift register (right shift, LSB first) and bit_cnt++.
  - After DATA_BITS samples -> STOP.
- STOP: on the OS_RATE-th os_tick, sample the stop bit. In the same clk:
  - rx_data <= shift register.
  - frame_err <= ~rxd_sync.
  - rda <= 1.
  - overrun <= 1 if rda=1 and clr_rda=0; otherwise overrun keeps its value.
  - state -> IDLE.
- A break frame (stop bit 0) loads data with frame_err=1. IDLE then re-arms only on a new falling edge, so a held-low line yields exactly one frame.
- clr_rda: rda <= 0 and overrun <= 0. If the load happens in the same clk, the load wins: rda=1, overrun unchanged.
- Latency: rda rises 1 clk after the stop-bit os_tick. That is about (1+DATA_BITS+0.5) bit times plus 3 clks after the start edge.
- os_tick asserted in IDLE is ignored. A falling edge outside IDLE is ignored.
- rx_data, frame_err and the shift register are not cleared by clr_rda.

Test Plan:
- Divisor giving os_tick every 4 clks; send 0xA5 8N1 -> rx_data=0xA5, rda=1, frame_err=0, overrun=0; rda rises ~9.5 bit times (608 clks) after the start edge.
- Low glitch of 3 os_ticks on rxd in IDLE -> START aborts at the 8th tick; busy returns to 0; rda stays 0.
- Send 0x3C with stop bit forced 0 -> rx_data=0x3C, frame_err=1, rda=1; line held low afterwards produces no second frame until rxd returns high then falls.
- Send 0x11 then 0x22 without clr_rda -> rx_data=0x22, rda=1, overrun=1; then a clr_rda pulse -> rda=0, overrun=0, rx_data=0x22.
- Pulse clr_rda in the same clk as the stop-bit load of 0x7E, with rda previously 1 -> rda=1, overrun unchanged, rx_data=0x7E.
- Assert rst_n low during the 4th data bit -> all outputs 0 immediately; after release, a clean 0x5A frame is received correctly.
